fetch_unit: RTL

- Instruction fetch stage for the tamarisc pipeline.
- Supplies `d_inst` to the decode/control block and consumes its `incr_pc` (advance) and `pc_load` (redirect) signals.
- Issues in-order word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch queue so decode stalls never drop fetched data.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: tamarisc instruction fetch stage with an in-order prefetch queue.
// Optional macro FETCH_BYPASS_EN forwards a returning word straight to decode in its arrival cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        pc_load_i,
    input  logic [31:0] pc_load_addr_i,
    input  logic        incr_pc_i,
    output logic [31:0] d_inst_o,
    output logic [31:0] d_pc_o,
    output logic        d_valid_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Headroom for back-to-back redirects that each leave responses in flight.
    localparam int unsigned DW = 8;

    logic [31:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [CW-1:0] reserved;
    logic [CW-1:0] nfilled;
    logic [DW-1:0] discard;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];

    logic [CW-1:0] unfilled;
    logic          grant;
    logic          fill;
    logic          bypass;
    logic          pop;
    logic [PW-1:0] gr_idx;
    logic [PW-1:0] wr_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^pc_load_addr_i[1:0];

    // Filled entries are always the oldest ones, so a fill count locates the next slot to fill.
    always_comb begin
        unfilled    = reserved - nfilled;
        imem_req_o  = !rst_i && !pc_load_i && (reserved < CW'(DEPTH));
        imem_addr_o = rst_i ? RESET_PC : fetch_pc;
        grant       = imem_req_o && imem_gnt_i;
        fill        = imem_rvalid_i && (discard == '0);
        gr_idx      = head + PW'(reserved);
        wr_idx      = head + PW'(nfilled);
`ifdef FETCH_BYPASS_EN
        bypass      = (reserved == CW'(1)) && (nfilled == '0) && fill;
`else
        bypass      = 1'b0;
`endif
        d_valid_o   = !rst_i && ((nfilled != '0) || bypass);
        d_inst_o    = NOP_INST;
        if (d_valid_o) begin
            d_inst_o = inst_q[head];
        end
`ifdef FETCH_BYPASS_EN
        if (d_valid_o && bypass) begin
            d_inst_o = imem_rdata_i;
        end
`endif
        if (rst_i) begin
            d_pc_o = RESET_PC;
        end else if (reserved != '0) begin
            d_pc_o = pc_q[head];
        end else begin
            d_pc_o = fetch_pc;
        end
        pop = d_valid_o && incr_pc_i && !pc_load_i;
    end

    // Queue payload storage; a bypassed word that is consumed at once is never written.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            pc_q[gr_idx] <= fetch_pc;
        end
        if (fill && !rst_i && !pc_load_i && !(bypass && pop)) begin
            inst_q[wr_idx] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            reserved <= '0;
            nfilled  <= '0;
            discard  <= '0;
        end else if (pc_load_i) begin
            fetch_pc <= {pc_load_addr_i[31:2], 2'b00};
            head     <= '0;
            reserved <= '0;
            nfilled  <= '0;
            discard  <= discard + DW'(unfilled) - DW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            reserved <= reserved + CW'(grant) - CW'(pop);
            nfilled  <= nfilled + CW'(fill) - CW'(pop);
            if (imem_rvalid_i && (discard != '0)) begin
                discard <= discard - DW'(1);
            end
        end
    end

    // Memory must never return a word nobody asked for.
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> ((unfilled != '0) || (discard != '0)));

endmodule
